// File: rtl/regfile_ctrl_if.sv
// Operand-request, response, writeback and RAM-side signals of the register-file sequencer.
// The master side is the CPU plus the RAM; the slave side is regfile_ctrl.
interface regfile_ctrl_if #(
    parameter int AW = 5
);
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_rs1;
    logic [AW-1:0] req_rs2;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rs1_data;
    logic [31:0]   rsp_rs2_data;

    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [31:0]   wb_data;

    logic          init_done;

    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [31:0]   mem_wr_data;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data;

    modport master (
        output req_valid, req_rs1, req_rs2, rsp_ready, wb_en, wb_addr, wb_data, mem_rd_data,
        input  req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, init_done,
               mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
    );

    modport slave (
        input  req_valid, req_rs1, req_rs2, rsp_ready, wb_en, wb_addr, wb_data, mem_rd_data,
        output req_ready, rsp_valid, rsp_rs1_data, rsp_rs2_data, init_done,
               mem_wr_en, mem_wr_addr, mem_wr_data, mem_rd_addr
    );
endinterface

// File: rtl/regfile_ctrl.sv
// Two-operand register-file read sequencer over a 1R1W RAM with a 1-cycle registered read.
// Reads rs1 then rs2, forwards writebacks seen during the read window, and zero-clears the RAM.
module regfile_ctrl #(
    parameter int SIZE           = 32,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic           CLK,
    input  logic           RST,
    regfile_ctrl_if.slave  bus
);
    localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;

    localparam logic [2:0] ST_CLEAR = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_RD1   = 3'd2;
    localparam logic [2:0] ST_RD2   = 3'd3;
    localparam logic [2:0] ST_RESP  = 3'd4;
    localparam logic [2:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);

    logic [2:0]    state_q,     state_d;
    logic [AW-1:0] clr_cnt_q,   clr_cnt_d;
    logic          init_done_q, init_done_d;
    logic [AW-1:0] rs1_idx_q,   rs1_idx_d;
    logic [AW-1:0] rs2_idx_q,   rs2_idx_d;
    logic [31:0]   rs1_data_q,  rs1_data_d;
    logic [31:0]   rs2_data_q,  rs2_data_d;
    logic          rs1_set_q,   rs1_set_d;
    logic          rs2_set_q,   rs2_set_d;
    logic [AW-1:0] rd_addr_q,   rd_addr_d;

    logic wb_live;
    logic hit1;
    logic hit2;

    assign wb_live = bus.wb_en && (bus.wb_addr != '0);

    // *_set flags mark an operand already holding its final value (forwarded or captured),
    // so a later stale RAM read must not overwrite it.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        clr_cnt_d   = clr_cnt_q;
        init_done_d = init_done_q;
        rs1_idx_d   = rs1_idx_q;
        rs2_idx_d   = rs2_idx_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        rs1_set_d   = rs1_set_q;
        rs2_set_d   = rs2_set_q;
        rd_addr_d   = rd_addr_q;
        hit1        = wb_live && (bus.wb_addr == rs1_idx_q);
        hit2        = wb_live && (bus.wb_addr == rs2_idx_q);

        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_IDX) begin
                    clr_cnt_d   = '0;
                    init_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (bus.req_valid) begin
                    rd_addr_d  = bus.req_rs1;
                    rs1_idx_d  = bus.req_rs1;
                    rs2_idx_d  = bus.req_rs2;
                    rs1_set_d  = wb_live && (bus.wb_addr == bus.req_rs1);
                    rs2_set_d  = wb_live && (bus.wb_addr == bus.req_rs2);
                    rs1_data_d = bus.wb_data;
                    rs2_data_d = bus.wb_data;
                    state_d    = ST_RD1;
                end
            end
            ST_RD1: begin
                rd_addr_d = rs2_idx_q;
                rs1_set_d = 1'b1;
                if (hit1)            rs1_data_d = bus.wb_data;
                else if (!rs1_set_q) rs1_data_d = bus.mem_rd_data;
                if (hit2) begin
                    rs2_data_d = bus.wb_data;
                    rs2_set_d  = 1'b1;
                end
                state_d = ST_RD2;
            end
            ST_RD2: begin
                if (hit1) rs1_data_d = bus.wb_data;
                if (hit2)            rs2_data_d = bus.wb_data;
                else if (!rs2_set_q) rs2_data_d = bus.mem_rd_data;
                if (rs1_idx_q == '0) rs1_data_d = '0;
                if (rs2_idx_q == '0) rs2_data_d = '0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_RESET;
        endcase
    end

    // The clear sweep owns the write port; reset suppresses any write in the reset cycle.
    always_comb begin
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = bus.wb_addr;
        bus.mem_wr_data = bus.wb_data;
        if (state_q == ST_CLEAR) begin
            bus.mem_wr_en   = 1'b1;
            bus.mem_wr_addr = clr_cnt_q;
            bus.mem_wr_data = '0;
        end else begin
            bus.mem_wr_en = wb_live;
        end
        if (RST) bus.mem_wr_en = 1'b0;
    end

    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.rsp_valid    = (state_q == ST_RESP);
    assign bus.rsp_rs1_data = rs1_data_q;
    assign bus.rsp_rs2_data = rs2_data_q;
    assign bus.init_done    = init_done_q;
    assign bus.mem_rd_addr  = rd_addr_d;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_RESET;
            clr_cnt_q   <= '0;
            init_done_q <= (CLEAR_ON_RESET == 1'b0);
            rs1_idx_q   <= '0;
            rs2_idx_q   <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            rs1_set_q   <= 1'b0;
            rs2_set_q   <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            init_done_q <= init_done_d;
            rs1_idx_q   <= rs1_idx_d;
            rs2_idx_q   <= rs2_idx_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            rs1_set_q   <= rs1_set_d;
            rs2_set_q   <= rs2_set_d;
            rd_addr_q   <= rd_addr_d;
        end
    end
endmodule

// File: tb/tb_regfile_ctrl.sv
// Scoreboard bench for regfile_ctrl: stimulus pushes expected operand pairs, a monitor pops
// and compares on every presented response; a behavioural RAM sits on the memory side.
module tb_regfile_ctrl;
    localparam int SIZE = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [63:0] exp_q[$];
    logic [31:0] ram     [SIZE];
    logic [31:0] ref_regs[SIZE];

    regfile_ctrl_if #(.AW(AW)) rf();

    regfile_ctrl #(.SIZE(SIZE), .CLEAR_ON_RESET(1'b1)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (rf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM: a read sharing an edge with a write to the same address returns old data.
    always @(posedge clk) begin
        if (rf.mem_wr_en) ram[rf.mem_wr_addr] <= rf.mem_wr_data;
        rf.mem_rd_data <= ram[rf.mem_rd_addr];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rf.rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", rf.rsp_valid, 1'b0);
            end else begin
                check("rsp_data", {rf.rsp_rs1_data, rf.rsp_rs2_data}, exp_q[0]);
                if (rf.rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wb(input logic en, input logic [AW-1:0] addr, input logic [31:0] data);
        rf.wb_en   = en;
        rf.wb_addr = addr;
        rf.wb_data = data;
        if (en && addr != '0) ref_regs[addr] = data;
    endtask

    task automatic do_req(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        int n = 0;
        rf.req_valid = 1'b1;
        rf.req_rs1   = r1;
        rf.req_rs2   = r2;
        @(negedge clk);
        while (!rf.req_ready && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        check("req_accept", rf.req_ready, 1'b1);
        check("rd_addr_rs1", rf.mem_rd_addr, r1);
        tick();
        rf.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Expects the clear sweep to start in the current cycle; optional wb pulse at step wb_at.
    task automatic clear_seq(input int wb_at);
        for (int i = 0; i < SIZE; i++) begin
            rf.wb_en   = (i == wb_at);
            rf.wb_addr = 5'd9;
            rf.wb_data = 32'h0000_0055;
            @(negedge clk);
            check($sformatf("clear_step%0d", i),
                  {rf.mem_wr_en, rf.mem_wr_addr, rf.mem_wr_data, rf.req_ready, rf.init_done, rf.rsp_valid},
                  {1'b1, AW'(i), 32'h0, 3'b000});
            tick();
        end
        rf.wb_en = 1'b0;
        @(negedge clk);
        check("clear_done", {rf.init_done, rf.req_ready, rf.mem_wr_en}, 3'b110);
        for (int i = 0; i < SIZE; i++) ref_regs[i] = '0;
        tick();
    endtask

    task automatic back_to_back();
        logic [AW-1:0] rs1_tab[5] = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd0};
        logic [AW-1:0] rs2_tab[5] = '{5'd2, 5'd1, 5'd3, 5'd5, 5'd6};
        logic [AW-1:0] p1 = '0;
        logic [AW-1:0] p2 = '0;
        int  n_req = 0;
        int  last_acc = -1;
        bit  pend = 1'b0;
        bit  acc;
        rf.rsp_ready = 1'b1;
        rf.req_valid = 1'b1;
        rf.req_rs1   = rs1_tab[0];
        rf.req_rs2   = rs2_tab[0];
        for (int c = 0; c < 60 && (n_req < 5 || pend); c++) begin
            drive_wb(c % 3 != 2, AW'((c * 5 + 1) % 8), 32'hA000_0000 + 32'(c));
            @(negedge clk);
            if (pend && cyc == last_acc + 2) begin
                exp_q.push_back({(p1 == '0) ? 32'h0 : ref_regs[p1], (p2 == '0) ? 32'h0 : ref_regs[p2]});
                pend = 1'b0;
            end
            acc = rf.req_valid && rf.req_ready;
            if (acc) begin
                if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, 4);
                last_acc = cyc;
                p1 = rf.req_rs1;
                p2 = rf.req_rs2;
                pend = 1'b1;
                n_req++;
            end
            tick();
            if (acc) begin
                if (n_req < 5) begin
                    rf.req_rs1 = rs1_tab[n_req];
                    rf.req_rs2 = rs2_tab[n_req];
                end else begin
                    rf.req_valid = 1'b0;
                end
            end
        end
        rf.req_valid = 1'b0;
        rf.wb_en     = 1'b0;
        check("b2b_count", n_req, 5);
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < SIZE; i++) begin
            ram[i]      = 32'hBAD0_0000 + 32'(i);
            ref_regs[i] = '0;
        end
        rf.req_valid = 1'b0;
        rf.req_rs1   = '0;
        rf.req_rs2   = '0;
        rf.rsp_ready = 1'b0;
        rf.wb_en     = 1'b0;
        rf.wb_addr   = '0;
        rf.wb_data   = '0;

        // Reset and initial clear sweep.
        repeat (3) tick();
        @(negedge clk);
        check("reset_ctrl", {rf.mem_wr_en, rf.init_done, rf.rsp_valid}, 3'b000);
        check("reset_data", {rf.rsp_rs1_data, rf.rsp_rs2_data}, 64'h0);
        tick();
        rst = 1'b0;
        clear_seq(-1);

        // Write x5, read (5,0) with a stalled consumer.
        drive_wb(1'b1, 5'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        check("wb_x5", {rf.mem_wr_en, rf.mem_wr_addr, rf.mem_wr_data}, {1'b1, 5'd5, 32'hDEAD_BEEF});
        tick();
        drive_wb(1'b0, 5'd0, 32'h0);
        exp_q.push_back({32'hDEAD_BEEF, 32'h0});
        do_req(5'd5, 5'd0);
        @(negedge clk); check("lat_t1", rf.rsp_valid, 1'b0); tick();
        @(negedge clk); check("lat_t2", rf.rsp_valid, 1'b0); tick();
        @(negedge clk); check("lat_t3", rf.rsp_valid, 1'b1);
        repeat (4) tick();
        rf.rsp_ready = 1'b1;
        tick();
        @(negedge clk);
        check("post_hs", {rf.req_ready, rf.rsp_valid}, 2'b10);
        tick();

        // rs1 == rs2 == 7 with writes at T and T+2 forwarded, T+3 ignored.
        drive_wb(1'b1, 5'd7, 32'h1);
        exp_q.push_back({32'h2, 32'h2});
        do_req(5'd7, 5'd7);
        drive_wb(1'b0, 5'd0, 32'h0);
        tick();
        drive_wb(1'b1, 5'd7, 32'h2);
        tick();
        drive_wb(1'b1, 5'd7, 32'h3);
        tick();
        drive_wb(1'b0, 5'd0, 32'h0);
        drain();
        exp_q.push_back({32'h3, 32'hDEAD_BEEF});
        do_req(5'd7, 5'd5);
        drain();

        // Writeback to x0 is dropped; x0 reads as zero.
        drive_wb(1'b1, 5'd0, 32'hFFFF_FFFF);
        @(negedge clk);
        check("wb_x0_dropped", rf.mem_wr_en, 1'b0);
        tick();
        exp_q.push_back({32'h0, 32'hDEAD_BEEF});
        do_req(5'd0, 5'd5);
        drive_wb(1'b0, 5'd0, 32'h0);
        drain();

        back_to_back();

        // Reset during RD1: request is dropped, clear restarts at 0, wb during clear ignored.
        do_req(5'd3, 5'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_seq(3);
        exp_q.push_back({32'h0, 32'h0});
        do_req(5'd5, 5'd9);
        drain();
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
- Sequencer that presents a two-operand register-file read interface on top of a single-read-port, single-write-port synchronous RAM (1-cycle registered read, write on clock edge).
- Issues the rs1 and rs2 reads back-to-back and forwards same-window writebacks.
- Hardwires register 0 to zero and zero-clears the RAM after reset.
- Sits between CPU decode/writeback and the register-file storage.

Parameters:
SIZE, 32, number of 32-bit registers; AW = $clog2(SIZE) is the address width.
CLEAR_ON_RESET, 1, 1 = zero every RAM entry after reset; 0 = go straight to IDLE.

Ports:
CLK  in  1  clock, all logic on posedge.
RST  in  1  synchronous reset, active-high.
req_valid  in  1  operand read request.
req_ready  out  1  request accepted when req_valid && req_ready.
req_rs1  in  AW  first operand index.
req_rs2  in  AW  second operand index.
rsp_valid  out  1  operands available.
rsp_ready  in  1  consumer takes operands.
rsp_rs1_data  out  32  value of rs1.
rsp_rs2_data  out  32  value of rs2.
wb_en  in  1  writeback strobe; no handshake.
wb_addr  in  AW  writeback index.
wb_data  in  32  writeback value.
init_done  out  1  high once the clear sequence has finished.
mem_wr_en  out  1  RAM write enable.
mem_wr_addr  out  AW  RAM write address.
mem_wr_data  out  32  RAM write data.
mem_rd_addr  out  AW  RAM read address.
mem_rd_data  in  32  RAM registered read data; valid the cycle after mem_rd_addr.

Behaviour:
- States: CLEAR, IDLE, RD1, RD2, RESP.
- Reset (any cycle, including mid-transaction):
  - State goes to CLEAR if CLEAR_ON_RESET, else IDLE. Any in-flight request is dropped.
  - rsp_valid=0, rsp_*_data=0, init_done=0 (1 if CLEAR_ON_RESET=0), mem_wr_en=0.
- CLEAR:
  - Counter runs 0..SIZE-1, one entry per cycle: mem_wr_en=1, mem_wr_addr=count, mem_wr_data=0.
  - Takes exactly SIZE cycles. After the last write the state goes to IDLE and init_done rises (registered).
  - During CLEAR, req_ready=0 and wb_en is ignored.
- req_ready = (state==IDLE), combinational. A request is accepted only in IDLE.
- Acceptance at cycle T:
  - T: mem_rd_addr=req_rs1. Latch rs1/rs2 indices. State goes to RD1.
  - T+1 (RD1): capture mem_rd_data as rs1 value. mem_rd_addr=rs2. State goes to RD2.
  - T+2 (RD2): capture mem_rd_data as rs2 value. State goes to RESP.
  - T+3: rsp_valid=1.
  - Fixed latency: 3 cycles from acceptance to rsp_valid.
- mem_rd_addr when idle: holds its last value (don't-care for verification).
- RESP:
  - rsp_valid and data are held stable until rsp_valid && rsp_ready.
  - After the handshake the state goes to IDLE; req_ready is high the next cycle.
  - Maximum throughput is one request per 4 cycles.
- Writeback (when not in CLEAR):
  - mem_wr_en=wb_en && wb_addr!=0, with mem_wr_addr/mem_wr_data = wb_addr/wb_data in the same cycle (combinational pass-through).
  - Writes to index 0 are dropped.
  - Writeback is accepted in every non-CLEAR state.
- Forwarding:
  - The RAM returns the old value when a read and a write to the same address share an edge.
  - Any wb_en write with wb_addr equal to an operand index, in cycles T through T+2 inclusive, overrides that operand's captured value. The latest such write wins.
  - Writes from T+3 onward are not reflected; response data is frozen.
  - If rs1==rs2, both operands receive identical forwarding.
- Index 0: an operand with index 0 returns 32'h0 regardless of RAM contents or forwarding.
- Out-of-range indices (>=SIZE, non-power-of-2 SIZE): undefined data, no hang.

Test Plan:
- Reset with CLEAR_ON_RESET=1, SIZE=32 -> exactly 32 cycles of mem_wr_en with addr 0..31, data 0. init_done rises the cycle after addr 31. req_ready=0 throughout, then 1.
- After init, write x5=32'hDEADBEEF; request rs1=5, rs2=0 at T -> rsp_valid at T+3 with rs1=DEADBEEF, rs2=0. Hold rsp_ready=0 for 4 cycles, then raise it -> data stable, req_ready=1 the following cycle.
- Request rs1=7, rs2=7 at T with wb x7=32'h1 at T and x7=32'h2 at T+2 -> both operands 32'h2. A further wb x7=32'h3 at T+3 -> response still 32'h2.
- wb_en to addr 0 with data 32'hFFFFFFFF -> mem_wr_en stays 0. Read rs1=0 -> 0.
- Assert RST at T+1 of an outstanding request -> rsp_valid never rises. Clear sequence restarts from addr 0. A wb_en pulse during CLEAR produces no write.
- Back-to-back requests with rsp_ready tied high -> acceptances exactly 4 cycles apart. Each response matches a RAM model including forwarded writes.
